mux5_arbiter: RTL and testbench

MUX5_ARBITER -- requirements
Module: mux5_arbiter

---
 rtl/mux5_arbiter.sv | 125 ++++++++++++
 tb/tb_mux5_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux5_arbiter.sv
// Round-robin arbiter driving the select of a 5:1 mux; registered one-hot grant, binary sel and valid.
// Optional hold-limit rotation is compiled in with `define MUX5_ARB_TIMEOUT_EN (MAX_HOLD = cycles per turn).
//
// state  | meaning
// S_IDLE | no grant, sel = 000, valid = 0
// S_OWN  | one requester owns the mux, sel = its index
module mux5_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req,
   output logic [4:0] grant,
   output logic [2:0] sel,
   output logic       valid
);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   generate
      if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
         $error("mux5_arbiter: MAX_HOLD must be 1..255");
      end
   endgenerate

   state_t     r_state, w_state_nxt;
   logic [4:0] r_grant, w_grant_nxt;
   logic [2:0] r_sel, w_sel_nxt;
   logic [2:0] r_ptr, w_ptr_nxt;
   logic       r_valid;
   logic       w_new;
   logic [4:0] w_pick_mask;
   logic       w_pick_found;
   logic [2:0] w_pick_idx;

   // First set bit of mask searching upward from start, wrapping 4 -> 0.
   function automatic logic [3:0] f_rr_pick(input logic [4:0] mask, input logic [2:0] start);
      logic       found;
      logic [2:0] idx;
      logic [3:0] cand;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 0; k < 5; k++) begin
         cand = {1'b0, start} + 4'(k);
         if (cand >= 4'd5) cand = cand - 4'd5;
         if (!found && mask[cand[2:0]]) begin
            found = 1'b1;
            idx   = cand[2:0];
         end
      end
      return {found, idx};
   endfunction

`ifdef MUX5_ARB_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       w_limit;

   // Counter holds owned cycles minus one, so the limit is reached during the MAX_HOLD-th cycle.
   assign w_limit = (r_cnt >= 8'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_cnt <= 8'd0;
      else if (w_new)                                r_cnt <= 8'd0;
      else if (r_state == S_OWN && r_cnt != 8'(MAX_HOLD)) r_cnt <= r_cnt + 8'd1;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_new       = 1'b0;
      w_pick_mask = req;
      case (r_state)
         S_IDLE: if (|req) w_new = 1'b1;
         S_OWN: begin
            if (!req[r_sel]) begin
               w_new = 1'b1;
            end
`ifdef MUX5_ARB_TIMEOUT_EN
            else if (w_limit && |(req & ~r_grant)) begin
               w_new       = 1'b1;
               w_pick_mask = req & ~r_grant;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
      {w_pick_found, w_pick_idx} = f_rr_pick(w_pick_mask, r_ptr);
      if (w_new) begin
         if (w_pick_found) begin
            w_state_nxt = S_OWN;
            w_grant_nxt = 5'd1 << w_pick_idx;
            w_sel_nxt   = w_pick_idx;
            w_ptr_nxt   = (w_pick_idx == 3'd4) ? 3'd0 : w_pick_idx + 3'd1;
         end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 5'd0;
            w_sel_nxt   = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= 5'd0;
         r_sel   <= 3'd0;
         r_ptr   <= 3'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_valid <= |w_grant_nxt;
      end
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign valid = r_valid;

endmodule

// File: tb/tb_mux5_arbiter.sv
// Self-checking bench for mux5_arbiter: directed scenarios plus random requests against a turn-based reference model.
module tb_mux5_arbiter;

   localparam int unsigned MAX_HOLD = 3;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic [4:0] grant;
   logic [2:0] sel;
   logic       valid;

   int n_cmp;
   int n_err;

   // reference model: current owner (-1 = none), next search start, cycles owned so far
   int m_owner;
   int m_ptr;
   int m_held;

   mux5_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .grant (grant),
      .sel   (sel),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rr_pick(input logic [4:0] mask, input int start);
      for (int k = 0; k < 5; k++)
         if (mask[(start + k) % 5]) return (start + k) % 5;
      return -1;
   endfunction

   function automatic logic [8:0] exp_out();
      if (m_owner < 0) return 9'd0;
      return {5'(1 << m_owner), 3'(m_owner), 1'b1};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   task automatic model_take(input int w);
      m_owner = w;
      if (w >= 0) begin
         m_ptr  = (w + 1) % 5;
         m_held = 1;
      end
   endtask

   task automatic model_edge(input logic [4:0] r);
      logic [4:0] others;
      if (m_owner < 0) begin
         model_take(rr_pick(r, m_ptr));
      end else if (!r[m_owner]) begin
         model_take(rr_pick(r, m_ptr));
      end else begin
         others = r;
         others[m_owner] = 1'b0;
`ifdef MUX5_ARB_TIMEOUT_EN
         if (m_held >= int'(MAX_HOLD) && others != 5'd0) model_take(rr_pick(others, m_ptr));
         else m_held++;
`else
         m_held++;
`endif
      end
   endtask

   // Called at a falling edge; returns at the next falling edge with the model advanced by one rising edge.
   task automatic step(input logic [4:0] r);
      req = r;
      @(posedge clk);
      model_edge(r);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = 5'd0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req   = 5'd0;
      rst_n = 1'b0;
      model_reset();
      #3;
      n_cmp++;
      if ({grant, sel, valid} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_state: got grant=%b sel=%b valid=%b, want all zero", grant, sel, valid);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(5'd0);
      n_cmp++;
      if ({grant, sel, valid} !== 9'd0) begin
         n_err++;
         $display("FAIL idle_after_release: got grant=%b sel=%b valid=%b, want all zero", grant, sel, valid);
      end
   endtask

   task automatic test_first_grant();
      step(5'b00100);
      n_cmp++;
      if ({grant, sel, valid} !== {5'b00100, 3'b010, 1'b1}) begin
         n_err++;
         $display("FAIL first_grant: got grant=%b sel=%b valid=%b, want 00100 010 1", grant, sel, valid);
      end
   endtask

   task automatic test_simultaneous_and_wrap();
      do_reset();
      step(5'b10010);
      n_cmp++;
      if ({grant, sel, valid} !== {5'b00010, 3'b001, 1'b1}) begin
         n_err++;
         $display("FAIL simultaneous: got grant=%b sel=%b valid=%b, want 00010 001 1", grant, sel, valid);
      end
      step(5'b10000);
      n_cmp++;
      if ({grant, sel, valid} !== {5'b10000, 3'b100, 1'b1}) begin
         n_err++;
         $display("FAIL handoff_to_4: got grant=%b sel=%b valid=%b, want 10000 100 1", grant, sel, valid);
      end
      step(5'b00001);
      n_cmp++;
      if ({grant, sel, valid} !== {5'b00001, 3'b000, 1'b1}) begin
         n_err++;
         $display("FAIL wrap_no_bubble: got grant=%b sel=%b valid=%b, want 00001 000 1", grant, sel, valid);
      end
      step(5'b00000);
      n_cmp++;
      if ({grant, sel, valid} !== 9'd0) begin
         n_err++;
         $display("FAIL release_to_idle: got grant=%b sel=%b valid=%b, want all zero", grant, sel, valid);
      end
   endtask

   task automatic test_hold_limit();
      int exp_idx[7];
`ifdef MUX5_ARB_TIMEOUT_EN
      exp_idx = '{0, 0, 0, 1, 1, 1, 0};
`else
      exp_idx = '{0, 0, 0, 0, 0, 0, 0};
`endif
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(5'b00011);
         n_cmp++;
         if (grant !== 5'(1 << exp_idx[i]) || sel !== 3'(exp_idx[i])) begin
            n_err++;
            $display("FAIL hold_limit[%0d]: got grant=%b sel=%b, want index %0d", i, grant, sel, exp_idx[i]);
         end
      end
   endtask

   task automatic test_single_holder();
      do_reset();
      for (int i = 0; i < 20; i++) step(5'b01000);
      n_cmp++;
      if ({grant, sel, valid} !== {5'b01000, 3'b011, 1'b1}) begin
         n_err++;
         $display("FAIL single_holder: got grant=%b sel=%b valid=%b, want 01000 011 1", grant, sel, valid);
      end
   endtask

   task automatic test_reset_midgrant();
      do_reset();
      step(5'b01000);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({grant, sel, valid} !== 9'd0) begin
         n_err++;
         $display("FAIL async_reset_midgrant: got grant=%b sel=%b valid=%b, want all zero", grant, sel, valid);
      end
      @(negedge clk);
      req = 5'd0;
      @(negedge clk);
      rst_n = 1'b1;
      step(5'b00000);
      n_cmp++;
      if ({grant, sel, valid} !== 9'd0) begin
         n_err++;
         $display("FAIL post_reset_idle: got grant=%b sel=%b valid=%b, want all zero", grant, sel, valid);
      end
   endtask

   task automatic test_random();
      logic [4:0] r;
      int         bad;
      do_reset();
      bad = 0;
      r   = 5'd0;
      for (int i = 0; i < 400; i++) begin
         // keep requests sticky so ownership and hold limits get exercised
         if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 31));
         else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 4)] ^= 1'b1;
         step(r);
         n_cmp++;
         if ({grant, sel, valid} !== exp_out() || sel > 3'd4 || $countones(grant) > 1) begin
            n_err++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d] req=%b: got grant=%b sel=%b valid=%b, want %b", i, r, grant, sel,
                        valid, exp_out());
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      req   = 5'd0;
      model_reset();
      test_reset();
      test_first_grant();
      test_simultaneous_and_wrap();
      test_hold_limit();
      test_single_holder();
      test_reset_midgrant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
